// File: rtl/datamover_package.sv
`default_nettype none
// -----------------------------------------------------------------------------
// datamover_package: shared types and helpers for the datamover TCDM arbiter.
// Revision: 1.0
// -----------------------------------------------------------------------------
package datamover_package;

  // Wide enough for any practical outstanding depth; the arbiter zero-extends.
  localparam int unsigned FLAGS_CNT_W = 16;

  typedef struct packed {
    logic [FLAGS_CNT_W-1:0] outstanding;
    logic                   empty;
    logic                   full;
    logic                   err;
  } flags_tcdm_arbiter_t;

  localparam int unsigned FLAGS_W = $bits(flags_tcdm_arbiter_t);

  function automatic int unsigned wrap_inc(int unsigned v, int unsigned n);
    return (v + 1 >= n) ? 32'd0 : v + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/datamover_tag_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// datamover_tag_fifo: register-based circular FIFO with count and sync clear.
// Revision: 1.0
// -----------------------------------------------------------------------------
module datamover_tag_fifo
  import datamover_package::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    if (clear_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/datamover_tcdm_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// datamover_tcdm_arbiter: round-robin NB_CHAN -> 1 TCDM arbiter, tagged replies.
// Revision: 1.0
// -----------------------------------------------------------------------------
module datamover_tcdm_arbiter
  import datamover_package::*;
#(
  parameter int unsigned NB_CHAN         = 2,
  parameter int unsigned DW              = 32,
  parameter int unsigned AW              = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            clear_i,
  input  logic                            enable_i,
  input  logic [NB_CHAN-1:0]              tcdm_slave_req_i,
  output logic [NB_CHAN-1:0]              tcdm_slave_gnt_o,
  input  logic [NB_CHAN-1:0][AW-1:0]      tcdm_slave_add_i,
  input  logic [NB_CHAN-1:0]              tcdm_slave_wen_i,
  input  logic [NB_CHAN-1:0][DW/8-1:0]    tcdm_slave_be_i,
  input  logic [NB_CHAN-1:0][DW-1:0]      tcdm_slave_data_i,
  output logic [NB_CHAN-1:0][DW-1:0]      tcdm_slave_r_data_o,
  output logic [NB_CHAN-1:0]              tcdm_slave_r_valid_o,
  output logic                            tcdm_master_req_o,
  input  logic                            tcdm_master_gnt_i,
  output logic [AW-1:0]                   tcdm_master_add_o,
  output logic                            tcdm_master_wen_o,
  output logic [DW/8-1:0]                 tcdm_master_be_o,
  output logic [DW-1:0]                   tcdm_master_data_o,
  input  logic [DW-1:0]                   tcdm_master_r_data_i,
  input  logic                            tcdm_master_r_valid_i,
  output logic [FLAGS_W-1:0]              flags_o
);

  localparam int unsigned ID_W  = $clog2(NB_CHAN);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            is_read;
  } tag_t;

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  lock_id_q, lock_id_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d;
  logic [ID_W-1:0]  sel;
  logic             stall, handshake;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  tag_t             push_tag, head;
  flags_tcdm_arbiter_t flags;

  function automatic logic [ID_W-1:0] chan_at(logic [ID_W-1:0] base, int unsigned k);
    int unsigned c;
    c = 32'(base) + k;
    if (c >= NB_CHAN) c = c - NB_CHAN;
    return ID_W'(c);
  endfunction

  // Scanning from the far end leaves the nearest requester at/after rr_ptr.
  always_comb begin
    sel = '0;
    if (lock_q) begin
      sel = lock_id_q;
    end else begin
      for (int k = int'(NB_CHAN) - 1; k >= 0; k--) begin
        if (tcdm_slave_req_i[chan_at(rr_ptr_q, unsigned'(k))]) sel = chan_at(rr_ptr_q, unsigned'(k));
      end
    end
  end

  assign stall              = fifo_full & ~tcdm_master_r_valid_i;
  assign tcdm_master_req_o  = enable_i & (|tcdm_slave_req_i) & ~stall;
  assign handshake          = tcdm_master_req_o & tcdm_master_gnt_i;
  assign tcdm_master_add_o  = tcdm_slave_add_i[sel];
  assign tcdm_master_wen_o  = tcdm_slave_wen_i[sel];
  assign tcdm_master_be_o   = tcdm_slave_be_i[sel];
  assign tcdm_master_data_o = tcdm_slave_data_i[sel];

  always_comb begin
    tcdm_slave_gnt_o      = '0;
    tcdm_slave_gnt_o[sel] = handshake;
  end

  // An empty head carries no valid owner, so a stray reply reaches nobody.
  always_comb begin
    tcdm_slave_r_valid_o = '0;
    if (tcdm_master_r_valid_i && !fifo_empty && head.is_read) begin
      tcdm_slave_r_valid_o[head.id] = 1'b1;
    end
  end

  for (genvar i = 0; i < int'(NB_CHAN); i++) begin : g_rdata
    assign tcdm_slave_r_data_o[i] = tcdm_master_r_data_i;
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    err_d     = err_q | (tcdm_master_r_valid_i & fifo_empty);
    if (handshake) begin
      rr_ptr_d = ID_W'(wrap_inc(32'(sel), NB_CHAN));
      lock_d   = 1'b0;
    end else if (tcdm_master_req_o) begin
      lock_d    = 1'b1;
      lock_id_d = sel;
    end
    if (clear_i) begin
      rr_ptr_d  = '0;
      lock_d    = 1'b0;
      lock_id_d = '0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
    end
  end

  assign push_tag = '{id: sel, is_read: tcdm_master_wen_o};

  datamover_tag_fifo #(
    .WIDTH ($bits(tag_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) i_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (handshake),
    .data_i  (push_tag),
    .pop_i   (tcdm_master_r_valid_i),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    flags.outstanding = FLAGS_CNT_W'(fifo_count);
    flags.empty       = fifo_empty;
    flags.full        = fifo_full;
    flags.err         = err_q;
  end

  assign flags_o = flags;

endmodule
`default_nettype wire

// File: tb/tb_datamover_tcdm_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_datamover_tcdm_arbiter: directed and random checks against a queue model.
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_datamover_tcdm_arbiter;
  import datamover_package::*;

  localparam int N    = 3;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int MAXO = 2;
  localparam int BW   = DW / 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   clear = 1'b0;
  logic                   en = 1'b1;
  logic [N-1:0]           s_req = '0;
  logic [N-1:0]           s_gnt;
  logic [N-1:0][AW-1:0]   s_add = '0;
  logic [N-1:0]           s_wen = '0;
  logic [N-1:0][BW-1:0]   s_be = '0;
  logic [N-1:0][DW-1:0]   s_data = '0;
  logic [N-1:0][DW-1:0]   s_rdata;
  logic [N-1:0]           s_rvalid;
  logic                   m_req;
  logic                   m_gnt = 1'b0;
  logic [AW-1:0]          m_add;
  logic                   m_wen;
  logic [BW-1:0]          m_be;
  logic [DW-1:0]          m_data;
  logic [DW-1:0]          m_rdata = '0;
  logic                   m_rvalid = 1'b0;
  logic [FLAGS_W-1:0]     flags_o;
  flags_tcdm_arbiter_t    f;

  assign f = flags_tcdm_arbiter_t'(flags_o);

  datamover_tcdm_arbiter #(
    .NB_CHAN(N), .DW(DW), .AW(AW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .clear_i              (clear),
    .enable_i             (en),
    .tcdm_slave_req_i     (s_req),
    .tcdm_slave_gnt_o     (s_gnt),
    .tcdm_slave_add_i     (s_add),
    .tcdm_slave_wen_i     (s_wen),
    .tcdm_slave_be_i      (s_be),
    .tcdm_slave_data_i    (s_data),
    .tcdm_slave_r_data_o  (s_rdata),
    .tcdm_slave_r_valid_o (s_rvalid),
    .tcdm_master_req_o    (m_req),
    .tcdm_master_gnt_i    (m_gnt),
    .tcdm_master_add_o    (m_add),
    .tcdm_master_wen_o    (m_wen),
    .tcdm_master_be_o     (m_be),
    .tcdm_master_data_o   (m_data),
    .tcdm_master_r_data_i (m_rdata),
    .tcdm_master_r_valid_i(m_rvalid),
    .flags_o              (flags_o)
  );

  always #5 clk = ~clk;

  // Reference model: outstanding transactions as a queue of {owner, is_read}.
  typedef struct { int id; bit rd; } mtag_t;
  mtag_t q[$];
  int    rr, lock_id, hs_ch, dut_ch;
  bit    locked, m_err, auto_drop;
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    rr = 0; locked = 0; lock_id = 0; m_err = 0;
    q.delete();
  endtask

  task automatic new_req(input int c, input bit wen);
    s_req[c]  = 1'b1;
    s_wen[c]  = wen;
    s_add[c]  = $urandom;
    s_be[c]   = BW'($urandom);
    s_data[c] = $urandom;
  endtask

  // Called with clk low; checks the current cycle, then advances one clock.
  task automatic step();
    int sel;
    bit found, stall, ereq;
    logic [N-1:0] eg, erv;
    #1;
    sel = 0; found = 0;
    if (locked) sel = lock_id;
    else begin
      for (int k = 0; k < N; k++) begin
        if (!found && s_req[(rr + k) % N]) begin sel = (rr + k) % N; found = 1; end
      end
    end
    stall = (q.size() == MAXO) && !m_rvalid;
    ereq  = en && (s_req != 0) && !stall;
    check_eq("m_req", m_req, ereq);
    if (ereq) begin
      check_eq("m_add", m_add, s_add[sel]);
      check_eq("m_wen", m_wen, s_wen[sel]);
      check_eq("m_be", m_be, s_be[sel]);
      check_eq("m_data", m_data, s_data[sel]);
    end
    eg = '0;
    if (ereq && m_gnt) eg[sel] = 1'b1;
    check_eq("s_gnt", s_gnt, eg);
    dut_ch = -1;
    for (int c = 0; c < N; c++) if (s_gnt[c]) dut_ch = c;
    erv = '0;
    if (m_rvalid && q.size() > 0 && q[0].rd) erv[q[0].id] = 1'b1;
    check_eq("s_rvalid", s_rvalid, erv);
    if (m_rvalid) check_eq("s_rdata", s_rdata[N-1], m_rdata);
    check_eq("outstanding", f.outstanding, q.size());
    check_eq("empty", f.empty, q.size() == 0);
    check_eq("full", f.full, q.size() == MAXO);
    check_eq("err", f.err, m_err);
    @(posedge clk);
    hs_ch = -1;
    if (clear) model_reset();
    else begin
      if (m_rvalid) begin
        if (q.size() > 0) q.delete(0);
        else m_err = 1;
      end
      if (ereq && m_gnt) begin
        q.push_back('{sel, s_wen[sel]});
        rr = (sel + 1) % N; locked = 0; hs_ch = sel;
      end else if (ereq) begin
        locked = 1; lock_id = sel;
      end
    end
    @(negedge clk);
    if (auto_drop && hs_ch >= 0) s_req[hs_ch] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    flags_tcdm_arbiter_t ef;
    ef = '{outstanding: '0, empty: 1'b1, full: 1'b0, err: 1'b0};
    check_eq({tag, "_flags"}, flags_o, ef);
    check_eq({tag, "_req"}, m_req, 1'b0);
    check_eq({tag, "_gnt"}, s_gnt, '0);
    check_eq({tag, "_rvalid"}, s_rvalid, '0);
  endtask

  initial begin
    int resp[$];
    int due, last_due;
    bit draining, done;
    model_reset();
    auto_drop = 1;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness: all channels request continuously with gnt always high.
    auto_drop = 0;
    for (int c = 0; c < N; c++) new_req(c, 1'b1);
    m_gnt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      m_rvalid = (i > 0); m_rdata = $urandom;
      step();
      check_eq("fair_order", dut_ch, i % N);
    end
    auto_drop = 1;
    s_req = '0; m_rvalid = 1'b1; step(); m_rvalid = 1'b0;

    // Single read on ch1, reply next cycle.
    new_req(1, 1'b1); s_add[1] = 32'h100;
    step();
    m_rvalid = 1'b1; m_rdata = 32'hCAFE; step();
    m_rvalid = 1'b0; step();

    // Lock: ch0 held on gnt=0 while ch1 waits, then enable dropped mid-lock.
    new_req(0, 1'b1); new_req(1, 1'b1);
    m_gnt = 1'b0;
    repeat (3) step();
    en = 1'b0; step(); en = 1'b1;
    m_gnt = 1'b1; step(); step();
    m_rvalid = 1'b1; repeat (2) step(); m_rvalid = 1'b0;

    // Write filtering: ch0 write, ch1 read, replies two cycles later.
    new_req(0, 1'b0); new_req(1, 1'b1);
    step(); step();
    step();
    m_rvalid = 1'b1; repeat (2) step(); m_rvalid = 1'b0;

    // Full boundary: third request stalls until a reply frees a slot.
    new_req(0, 1'b1); new_req(1, 1'b1);
    step(); step();
    new_req(2, 1'b0);
    step();
    m_rvalid = 1'b1; step();
    repeat (2) step(); m_rvalid = 1'b0;

    // Error, then clear restores pointer and sticky error.
    new_req(1, 1'b1); step();
    m_rvalid = 1'b1; step();
    step();
    m_rvalid = 1'b0; step();
    clear = 1'b1; step(); clear = 1'b0;
    for (int c = 0; c < N; c++) new_req(c, 1'b1);
    m_gnt = 1'b0; step();
    m_gnt = 1'b1; step();
    m_gnt = 1'b0; step();

    // Async reset in the middle of a locked, outstanding transaction.
    #2;
    s_req = '0; m_rvalid = 1'b1; rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; m_rvalid = 1'b0;
    for (int c = 0; c < N; c++) new_req(c, 1'b1);
    m_gnt = 1'b1; step();
    s_req = '0; m_rvalid = 1'b1; step(); m_rvalid = 1'b0;

    // Random traffic against an in-order memory with variable reply latency.
    last_due = 0; draining = 0; done = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      draining = (cyc >= 1500);
      if (draining && s_req == 0 && resp.size() == 0) begin done = 1; break; end
      m_rvalid = 1'b0;
      if (resp.size() > 0 && resp[0] <= cyc) begin
        m_rvalid = 1'b1; m_rdata = $urandom; resp.delete(0);
      end
      m_gnt = ($urandom_range(0, 3) != 0);
      en    = draining ? 1'b1 : ($urandom_range(0, 9) != 0);
      for (int c = 0; c < N; c++) begin
        if (!s_req[c] && !draining && $urandom_range(0, 2) == 0) new_req(c, 1'($urandom_range(0, 1)));
      end
      step();
      if (hs_ch >= 0) begin
        due = cyc + int'($urandom_range(1, 5));
        if (due < last_due) due = last_due;
        last_due = due;
        resp.push_back(due);
      end
    end
    check_eq("drain_done", done, 1'b1);
    m_rvalid = 1'b0;
    step();
    check_eq("final_outstanding", f.outstanding, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/datamover_tcdm_arbiter.md
# datamover_tcdm_arbiter

Parametrised successor to the datamover's single load/store TCDM merge stage. It round-robin arbitrates `NB_CHAN` virtual HCI TCDM channels from streamer sources and sinks onto one HCI TCDM master port. Returned `r_valid`/`r_data` is routed back to the originating channel through an in-order tag FIFO, and write responses are filtered internally. It sits between the streamer's `hci_core_source`/`hci_core_sink` instances and the TCDM port, replacing the separate mux and r_valid filter.

## Interface
- `NB_CHAN`, default 2, number of virtual channels; must be ≥ 2.
- `DW`, default 32, data width.
- `AW`, default 32, address width.
- `MAX_OUTSTANDING`, default 4, tag FIFO depth, i.e. the maximum number of granted but unanswered transactions; must be ≥ 1.
- `clk_i`, input, 1, clock.
- `rst_ni`, input, 1, asynchronous active-low reset.
- `clear_i`, input, 1, synchronous clear; returns all state to reset values.
- `enable_i`, input, 1, when low no new requests are forwarded; responses still drain.
- `tcdm_slave`, `hci_core_intf.slave [NB_CHAN]`, uses fields req, gnt, add[AW], wen, be[DW/8], data[DW], r_data[DW], r_valid.
- `tcdm_master`, `hci_core_intf.master`, same fields, toward memory.
- `flags_o`, output, `flags_tcdm_arbiter_t`, fields: `outstanding` [$clog2(MAX_OUTSTANDING+1)], `empty`, `full`, `err` (sticky).

## Operation
- Selection:
  - If `lock` is set, the selected channel is `lock_id`.
  - Otherwise it is the first requesting channel at or after `rr_ptr`, searching upward with wrap-around.
- Forwarding:
  - `tcdm_master.req = enable_i & any_req & ~stall`.
  - add, wen, be and data are muxed from the selected channel.
  - `tcdm_slave[sel].gnt = tcdm_master.gnt & tcdm_master.req`. All other gnt outputs are 0.
- Lock:
  - When master req=1 and gnt=0: set `lock`=1 and `lock_id`=sel. The request is held to the same channel until granted.
  - On handshake, clear `lock`.
- Round-robin pointer: on handshake, `rr_ptr` ← (sel+1) mod NB_CHAN. It is unchanged otherwise.
- Tag FIFO:
  - Every handshake pushes {id=sel, is_read=wen}.
  - Every `tcdm_master.r_valid` pops the head.
- Response routing:
  - `tcdm_slave[head.id].r_valid = tcdm_master.r_valid & head.is_read`.
  - `r_data` is broadcast to all channels.
  - A write pop produces no slave r_valid.
- Stall: `stall = (count == MAX_OUTSTANDING) & ~tcdm_master.r_valid`. A pop and a push in the same cycle is permitted when the FIFO is full.
- Error: `r_valid` arriving with the FIFO empty sets `err`. That response is dropped and the count stays 0. `err` is cleared only by reset or clear_i.
- `enable_i`=0 while `lock`=1: req drops. The lock is retained and the request resumes on the same channel.
- `clear_i` is honoured at any time, but is legal only when `outstanding`==0; otherwise in-flight responses are dropped and set `err`.

## Timing
- Request path is combinational slave→master, with zero added latency.
- Response path is combinational from master r_valid to slave r_valid through the FIFO head register, with zero added latency.
- Reset and clear values:
  - `rr_ptr`=0, `lock`=0, `lock_id`=0.
  - FIFO empty, count=0.
  - `flags_o`: outstanding=0, empty=1, full=0, err=0.
  - All gnt/r_valid=0, master req=0.
- Count update each cycle: +push −pop. It saturates neither way: underflow is prevented by the err rule, and overflow by the stall rule.
- Memory may return r_valid any number of cycles after gnt; ordering must be preserved.

## Structure
- Package `datamover_package`: `flags_tcdm_arbiter_t`, and a tag struct `{logic [$clog2(NB_CHAN)-1:0] id; logic is_read;}`, parametrised via a localparam in the module.
- One sub-module, `datamover_tag_fifo`: a register-based circular FIFO with width and depth parameters, push/pop/full/empty/count outputs, and clear.
- The arbiter logic (rr_ptr, lock, muxes) is inline.

## Test plan
- **Single channel:** NB_CHAN=2, ch1 reads add 0x100; memory gnt same cycle, r_valid +1 cycle with 0xCAFE → ch1 r_valid=1 with 0xCAFE; ch0 r_valid=0; outstanding 0→1→0.
- **Fairness:** NB_CHAN=3, all channels request continuously, gnt always 1 → grant order 0,1,2,0,1,2; rr_ptr wraps.
- **Lock:** ch0 requests, gnt held 0 for 3 cycles while ch1 also requests → master add stays ch0's, ch1 gnt=0; after ch0 gnt, ch1 is granted next cycle.
- **Write filtering:** interleaved ch0 write and ch1 read, responses delayed 2 cycles → only ch1 sees r_valid; FIFO pops twice.
- **Full boundary:** MAX_OUTSTANDING=2, memory withholds r_valid → third request stalls (req=0, full=1); r_valid arriving in the same cycle as the pending request → push and pop together, count stays 2.
- **Reset/clear/error:** spurious r_valid with empty FIFO → err=1, no slave r_valid; clear_i → err=0, rr_ptr=0; async rst_ni mid-transaction → all outputs return to reset values immediately.
